mem_writeback_stage: RTL and testbench

- Parametrised MEM and MEM/WB stage for the pipelined microprocessor; sits after Execute and consumes the EX/MEM buffered signals.
- Holds the word-addressed data RAM and registers the MEM/WB pipeline buffer.
- Drives the register-file write port and the Execute forwarding inputs (memWbRegWrite, memWbRd, memWbData).
- Adds a post-reset RAM clear sequence and a stall/flush interface.

---
 rtl/mem_writeback_stage.sv | 139 +++++++++++++
 tb/tb_mem_writeback_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_writeback_stage.sv
// MEM and MEM/WB stage: word-addressed data RAM with a post-reset clear sequence,
// the MEM/WB pipeline buffer with stall/flush, and an optional LED register (MMIO_LED_EN).
module mem_writeback_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LED_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                writeBackControlIn,
    input  logic [2:0]                memAccessControlIn,
    input  logic [DATA_WIDTH-1:0]     result,
    input  logic [DATA_WIDTH-1:0]     writeData,
    input  logic [REG_ADDR_WIDTH-1:0] rdIn,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      busy,
    output logic                      memWbRegWrite,
    output logic [REG_ADDR_WIDTH-1:0] memWbRd,
    output logic [DATA_WIDTH-1:0]     memWbData,
    output logic [LED_WIDTH-1:0]      led
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, RUN} stateT;

    stateT                    stateReg, stateNext;
    logic [ADDR_WIDTH-1:0]    clearCntReg, clearCntNext;
    logic [DATA_WIDTH-1:0]    ram [DEPTH];

    logic                     regWrite, memToReg, memWrite;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    readWord;
    logic                     isLedAddr, clearIsTop;

    logic                     ramWe;
    logic [ADDR_WIDTH-1:0]    ramWAddr;
    logic [DATA_WIDTH-1:0]    ramWData;

    logic                     memWbRegWriteReg;
    logic [REG_ADDR_WIDTH-1:0] memWbRdReg;
    logic [DATA_WIDTH-1:0]    memWbDataReg;

    // Byte-offset bits, high address bits, memRead and branch do not influence this stage.
    logic unusedBits;
    assign unusedBits = ^{result[DATA_WIDTH-1:ADDR_WIDTH+2], result[1:0],
                          memAccessControlIn[2], memAccessControlIn[0]};

    assign regWrite = writeBackControlIn[0];
    assign memToReg = writeBackControlIn[1];
    assign memWrite = memAccessControlIn[1];
    assign addr     = result[ADDR_WIDTH+1:2];
    assign busy     = (stateReg == CLEAR);

`ifdef MMIO_LED_EN
    logic [LED_WIDTH-1:0] ledReg;

    // The all-ones word address is the LED register; the RAM word behind it is never written.
    assign isLedAddr  = &addr;
    assign clearIsTop = &clearCntReg;
    assign readWord   = isLedAddr ? DATA_WIDTH'(ledReg) : ram[addr];
    assign led        = ledReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ledReg <= '0;
        end else if (stateReg == RUN && memWrite && !stall && isLedAddr) begin
            ledReg <= writeData[LED_WIDTH-1:0];
        end
    end
`else
    assign isLedAddr  = 1'b0;
    assign clearIsTop = 1'b0;
    assign readWord   = ram[addr];
    assign led        = {LED_WIDTH{1'b0}};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= CLEAR;
            clearCntReg <= '0;
        end else begin
            stateReg    <= stateNext;
            clearCntReg <= clearCntNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        clearCntNext = clearCntReg;
        ramWe        = 1'b0;
        ramWAddr     = addr;
        ramWData     = writeData;
        case (stateReg)
            CLEAR: begin
                ramWe        = !clearIsTop;
                ramWAddr     = clearCntReg;
                ramWData     = '0;
                clearCntNext = clearCntReg + 1'b1;
                if (clearCntReg == {ADDR_WIDTH{1'b1}}) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                ramWe = memWrite && !stall && !isLedAddr;
            end
            default: begin
                stateNext = CLEAR;
            end
        endcase
    end

    // Single write port shared by the clear sequence and pipeline stores.
    always_ff @(posedge clk) begin
        if (ramWe && !reset) begin
            ram[ramWAddr] <= ramWData;
        end
    end

    // Flush takes priority over stall; the clear sequence only ever inserts bubbles.
    always_ff @(posedge clk) begin
        if (reset || stateReg == CLEAR || flush) begin
            memWbRegWriteReg <= 1'b0;
            memWbRdReg       <= '0;
            memWbDataReg     <= '0;
        end else if (!stall) begin
            memWbRegWriteReg <= regWrite && (rdIn != '0);
            memWbRdReg       <= rdIn;
            memWbDataReg     <= memToReg ? readWord : result;
        end
    end

    assign memWbRegWrite = memWbRegWriteReg;
    assign memWbRd       = memWbRdReg;
    assign memWbData     = memWbDataReg;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Self-checking bench for mem_writeback_stage: a cycle-level model of the stage's rules
// is compared every cycle, plus directed literal expectations.
module tb_mem_writeback_stage;

    localparam int DEPTH = 64;
`ifdef MMIO_LED_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wbCtl;
    logic [2:0]  macCtl;
    logic [31:0] result, writeData;
    logic [4:0]  rdIn;
    logic        stall, flush;
    logic        busy, memWbRegWrite;
    logic [4:0]  memWbRd;
    logic [31:0] memWbData;
    logic [7:0]  led;

    always #5 clk = ~clk;

    mem_writeback_stage #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .REG_ADDR_WIDTH(5), .LED_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset),
        .writeBackControlIn(wbCtl), .memAccessControlIn(macCtl),
        .result(result), .writeData(writeData), .rdIn(rdIn),
        .stall(stall), .flush(flush),
        .busy(busy), .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd),
        .memWbData(memWbData), .led(led)
    );

    int tests = 0;
    int fails = 0;
    bit checkEn = 1'b0;

    // Model state: clear cycles still to run, memory contents, LED and expected buffer.
    int          clearLeft = 0;
    logic [31:0] mMem [DEPTH];
    logic [7:0]  mLed = '0;
    logic        expRW = 1'b0;
    logic [4:0]  expRd = '0;
    logic [31:0] expData = '0;

    int          pClear;
    logic        pRW;
    logic [4:0]  pRd;
    logic [31:0] pData;
    logic [7:0]  pLed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic modelStep();
        int word;
        logic [31:0] rdv;
        pClear = clearLeft; pRW = expRW; pRd = expRd; pData = expData; pLed = mLed;
        if (reset) begin
            pClear = DEPTH; pRW = 1'b0; pRd = '0; pData = '0; pLed = '0;
        end else if (clearLeft > 0) begin
            word = DEPTH - clearLeft;
            if (!(MMIO && word == DEPTH - 1)) mMem[word] = '0;
            pClear = clearLeft - 1;
            pRW = 1'b0; pRd = '0; pData = '0;
        end else begin
            word = int'((result >> 2) % DEPTH);
            rdv  = (MMIO && word == DEPTH - 1) ? {24'h0, mLed} : mMem[word];
            if (flush) begin
                pRW = 1'b0; pRd = '0; pData = '0;
            end else if (!stall) begin
                pRW   = wbCtl[0] && (rdIn != 0);
                pRd   = rdIn;
                pData = wbCtl[1] ? rdv : result;
            end
            if (macCtl[1] && !stall) begin
                if (MMIO && word == DEPTH - 1) pLed = writeData[7:0];
                else mMem[word] = writeData;
            end
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        clearLeft = pClear; expRW = pRW; expRd = pRd; expData = pData; mLed = pLed;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            check("busy", busy, clearLeft > 0);
            check("memWbRegWrite", memWbRegWrite, expRW);
            check("memWbRd", memWbRd, expRd);
            check("memWbData", memWbData, expData);
            check("led", led, mLed);
        end
    end

    task automatic setIdle();
        wbCtl = '0; macCtl = '0; result = '0; writeData = '0; rdIn = '0; stall = 0; flush = 0;
    endtask

    task automatic txn(input logic [1:0] wb, input logic [2:0] mac, input logic [31:0] res,
                       input logic [31:0] wd, input logic [4:0] rd, input logic st, input logic fl);
        wbCtl = wb; macCtl = mac; result = res; writeData = wd; rdIn = rd; stall = st; flush = fl;
        tick();
        $display("[TB] txn wb=%0d mac=%0d res=%h wd=%h rd=%0d stall=%0d flush=%0d -> rw=%0d rd=%0d data=%h led=%h",
                 wb, mac, res, wd, rd, st, fl, memWbRegWrite, memWbRd, memWbData, led);
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        setIdle();
        tick();
        tick();
        checkEn = 1'b1;
        check("reset_busy", busy, 1);
        check("reset_regwrite", memWbRegWrite, 0);
        check("reset_data", memWbData, 0);
        check("reset_led", led, 0);

        reset = 1'b0;
        countBusy(n);
        check("clear_length", n, 64);

        // Reset again, then re-assert reset 20 cycles into the clear.
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (20) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        countBusy(n);
        check("clear_restart_length", n, 64);

        txn(2'd3, 3'd1, 32'h0000_0080, 32'h0, 5'd1, 1'b0, 1'b0);
        check("cleared_load_data", memWbData, 32'h0);

        txn(2'd0, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
        txn(2'd3, 3'd1, 32'h0000_0010, 32'h0, 5'd3, 1'b0, 1'b0);
        check("load_after_store_rw", memWbRegWrite, 1);
        check("load_after_store_rd", memWbRd, 3);
        check("load_after_store_data", memWbData, 32'hDEAD_BEEF);

        txn(2'd0, 3'd2, 32'h0000_0110, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0);
        txn(2'd3, 3'd1, 32'h0000_0010, 32'h0, 5'd3, 1'b0, 1'b0);
        check("alias_data", memWbData, 32'hCAFE_F00D);

        txn(2'd1, 3'd0, 32'h0000_0005, 32'h0, 5'd0, 1'b0, 1'b0);
        check("rd0_regwrite", memWbRegWrite, 0);
        check("rd0_data", memWbData, 32'h5);

        txn(2'd1, 3'd0, 32'h0000_1234, 32'h0, 5'd7, 1'b0, 1'b0);
        check("alu_data", memWbData, 32'h1234);

        txn(2'd1, 3'd0, 32'h0000_0055, 32'h0, 5'd9, 1'b0, 1'b0);
        txn(2'd3, 3'd2, 32'h0000_0020, 32'h1234_5678, 5'd4, 1'b1, 1'b0);
        txn(2'd3, 3'd2, 32'h0000_0020, 32'h1234_5678, 5'd4, 1'b1, 1'b0);
        check("stall_hold_rd", memWbRd, 9);
        check("stall_hold_data", memWbData, 32'h55);
        txn(2'd3, 3'd1, 32'h0000_0020, 32'h0, 5'd6, 1'b0, 1'b0);
        check("stall_no_store", memWbData, 32'h0);

        txn(2'd1, 3'd2, 32'h0000_0030, 32'h0000_0077, 5'd5, 1'b0, 1'b1);
        check("flush_regwrite", memWbRegWrite, 0);
        check("flush_rd", memWbRd, 0);
        txn(2'd3, 3'd1, 32'h0000_0030, 32'h0, 5'd5, 1'b0, 1'b0);
        check("flush_store_kept", memWbData, 32'h77);

        txn(2'd1, 3'd2, 32'h0000_0034, 32'h0000_0099, 5'd5, 1'b1, 1'b1);
        check("flush_stall_regwrite", memWbRegWrite, 0);
        txn(2'd3, 3'd1, 32'h0000_0034, 32'h0, 5'd5, 1'b0, 1'b0);
        check("flush_stall_no_store", memWbData, 32'h0);

        txn(2'd3, 3'd3, 32'h0000_0010, 32'h1111_1111, 5'd2, 1'b0, 1'b0);
        check("rw_same_cycle_old", memWbData, 32'hCAFE_F00D);
        txn(2'd3, 3'd1, 32'h0000_0010, 32'h0, 5'd2, 1'b0, 1'b0);
        check("rw_same_cycle_new", memWbData, 32'h1111_1111);

        txn(2'd0, 3'd2, 32'h0000_00FC, 32'h0000_00A5, 5'd0, 1'b0, 1'b0);
        check("top_store_led", led, MMIO ? 32'hA5 : 32'h0);
        txn(2'd3, 3'd1, 32'h0000_00FC, 32'h0, 5'd8, 1'b0, 1'b0);
        check("top_load", memWbData, 32'h0000_00A5);

        txn(2'd0, 3'd2, 32'h0000_01FC, 32'h1234_56C3, 5'd0, 1'b0, 1'b0);
        txn(2'd3, 3'd1, 32'h0000_00FC, 32'h0, 5'd8, 1'b0, 1'b0);
        check("top_alias_load", memWbData, MMIO ? 32'h0000_00C3 : 32'h1234_56C3);

        // Garbage control during the clear sequence must change nothing.
        reset = 1'b1; tick(); reset = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            wbCtl = 2'd3; macCtl = 3'd3; rdIn = 5'd7;
            result = $urandom; writeData = $urandom;
            stall = n[0]; flush = 1'b0;
            n++;
            tick();
        end
        setIdle();
        check("garbage_clear_length", n, 64);
        check("garbage_led", led, 0);
        txn(2'd3, 3'd1, 32'h0000_0010, 32'h0, 5'd3, 1'b0, 1'b0);
        check("garbage_load_data", memWbData, 32'h0);

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
